// File: rtl/dump_pkg.sv
// Shared definitions for the debug dump sequencer: FSM state encoding,
// word-index layout of a dump and the total-word helper.
package dump_pkg;

  localparam int DUMP_DATA_W    = 32;
  localparam int DUMP_BYTE_W    = 8;
  localparam int BYTES_PER_WORD = DUMP_DATA_W / DUMP_BYTE_W;

  // Word order of a dump: PC, cycle count, then register file, then memory.
  localparam int IDX_PC   = 0;
  localparam int IDX_CYC  = 1;
  localparam int IDX_REG0 = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_t;

  function automatic int total_words(input int nreg, input int nmem);
    return IDX_REG0 + nreg + nmem;
  endfunction

endpackage

// File: rtl/dump_byte_tx.sv
// Byte serializer for one dump word: shift register, byte counter, tx_start
// pulse generation and tx_done_tick rising-edge detection.
module dump_byte_tx
  import dump_pkg::*;
#(
  parameter int DATA_W = DUMP_DATA_W,
  parameter int BYTE_W = DUMP_BYTE_W,
  parameter int NBYTES = BYTES_PER_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  input  logic              waiting,
  input  logic              tx_done_tick,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  output logic              byte_sent,
  output logic              word_sent
);

  localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shifted;
  logic [CNT_W-1:0]  cnt_q;
  logic              tick_q;
  logic              tick_edge;

  // A tick that is already high on entry to WAIT shows tick_q=1 and is ignored.
  assign shifted   = shift_q >> BYTE_W;
  assign tick_edge = waiting & tx_done_tick & ~tick_q;
  assign byte_sent = tick_edge & (cnt_q != LAST_BYTE);
  assign word_sent = tick_edge & (cnt_q == LAST_BYTE);

  // NOTE: non-blocking assignments so every register here samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: datapath registers are reset as well so tx_data reads 0 before any dump.
      shift_q  <= '0;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tick_q   <= tx_done_tick;
      tx_start <= load | byte_sent;
      if (load) begin
        shift_q <= word;
        cnt_q   <= '0;
        tx_data <= word[BYTE_W-1:0];
      end else if (byte_sent) begin
        shift_q <= shifted;
        cnt_q   <= cnt_q + CNT_W'(1);
        tx_data <= shifted[BYTE_W-1:0];
      end
    end
  end

endmodule

// File: rtl/dump_sequencer.sv
// Streams a MIPS state snapshot (PC, cycles, registers) over the UART TX after
// a halt/step. Define DUMP_MEM_EN to append data-memory words to the dump.
module dump_sequencer
  import dump_pkg::*;
#(
  parameter int DATA_W = DUMP_DATA_W,
  parameter int BYTE_W = DUMP_BYTE_W,
  parameter int NREG   = 32,
  parameter int REG_AW = 5,
  parameter int NMEM   = 32,
  parameter int MEM_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] cycles_in,
  output logic [REG_AW-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_data,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  input  logic              tx_done_tick,
  output logic              busy,
  output logic              done
);

`ifdef DUMP_MEM_EN
  localparam int NMEM_DUMP = NMEM;
`else
  localparam int NMEM_DUMP = 0;
`endif
  localparam int TOTAL_WORDS = total_words(NREG, NMEM_DUMP);
  localparam int IDX_W       = $clog2(TOTAL_WORDS + 1);

  localparam logic [IDX_W-1:0] PC_IDX   = IDX_W'(IDX_PC);
  localparam logic [IDX_W-1:0] CYC_IDX  = IDX_W'(IDX_CYC);
  localparam logic [IDX_W-1:0] REG_BASE = IDX_W'(IDX_REG0);
  localparam logic [IDX_W-1:0] MEM_BASE = IDX_W'(IDX_REG0 + NREG);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_WORDS - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] pc_q, cyc_q, word;
  logic              load, waiting, byte_sent, word_sent;
  logic              in_reg;

  // Indices outside a range drive address 0 on that port.
  assign in_reg   = (idx_q >= REG_BASE) && (idx_q < MEM_BASE);
  assign reg_addr = in_reg ? REG_AW'(idx_q - REG_BASE) : '0;

`ifdef DUMP_MEM_EN
  logic in_mem;
  assign in_mem   = idx_q >= MEM_BASE;
  assign mem_addr = in_mem ? MEM_AW'(idx_q - MEM_BASE) : '0;
`else
  logic unused_mem;
  assign unused_mem = ^mem_data;
  assign mem_addr   = '0;
`endif

  always_comb begin
    word = '0;
    if (idx_q == PC_IDX)       word = pc_q;
    else if (idx_q == CYC_IDX) word = cyc_q;
    else if (in_reg)           word = reg_data;
`ifdef DUMP_MEM_EN
    else if (in_mem)           word = mem_data;
`endif
  end

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d = state_q;
    load    = 1'b0;
    waiting = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: begin
        busy    = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        busy    = 1'b1;
        load    = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        busy    = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        busy    = 1'b1;
        waiting = 1'b1;
        if (byte_sent)      state_d = S_SEND;
        else if (word_sent) state_d = (idx_q == LAST_IDX) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pc_q    <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE) begin
        idx_q <= '0;
        if (start) begin
          pc_q  <= pc_in;
          cyc_q <= cycles_in;
        end
      end else if (word_sent && idx_q != LAST_IDX) begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  dump_byte_tx #(
    .DATA_W(DATA_W),
    .BYTE_W(BYTE_W),
    .NBYTES(DATA_W / BYTE_W)
  ) u_byte_tx (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .word        (word),
    .waiting     (waiting),
    .tx_done_tick(tx_done_tick),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .byte_sent   (byte_sent),
    .word_sent   (word_sent)
  );

endmodule

// File: tb/tb_dump_sequencer.sv
// Directed bench for dump_sequencer: scoreboard of expected UART bytes, a UART
// tick model with two timing modes, and register/memory read-port models.
module tb_dump_sequencer;
  import dump_pkg::*;

`ifdef DUMP_MEM_EN
  localparam int EXP_BYTES = 264;
`else
  localparam int EXP_BYTES = 136;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] cycles_in = '0;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data = '0;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data = '0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done_tick = 1'b0;
  logic        busy;
  logic        done;

  dump_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pc_in       (pc_in),
    .cycles_in   (cycles_in),
    .reg_addr    (reg_addr),
    .reg_data    (reg_data),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done_tick(tx_done_tick),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Synchronous read ports: data valid one cycle after the address.
  always @(posedge clk) begin
    reg_data <= 32'h0101_0100 + 32'(reg_addr);
    mem_data <= 32'hA5A5_0000 + 32'(mem_addr);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] sb[$];
  int         tx_total = 0, done_total = 0;
  int         first_tx_cyc = 0, last_tx_cyc = 0, done_cyc = 0;
  logic [7:0] first_byte = '0;
  int         gap_bad = 0, stab_bad = 0;
  int         mode = 0;
  int         since = 1000;
  logic       stab_en = 1'b0;
  logic [7:0] prev_tx_data = '0;
  int         pos, exp_gap;
  logic [7:0] exp_byte;
  int         base_tx, base_done, start_cyc, busy_low;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) sb.push_back(w[8*b +: 8]);
  endtask

  task automatic push_dump(input logic [31:0] pc, input logic [31:0] cy);
    push_word(pc);
    push_word(cy);
    for (int k = 0; k < 32; k++) push_word(32'h0101_0100 + 32'(k));
`ifdef DUMP_MEM_EN
    for (int k = 0; k < 32; k++) push_word(32'hA5A5_0000 + 32'(k));
`endif
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start     = 1'b1;
    start_cyc = cyc;
    check("busy_before_start", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_tx(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (tx_total >= target) break;
    end
    check("wait_tx_reached", 32'(tx_total >= target), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    busy_low = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) break;
      if (busy !== 1'b1) busy_low++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
  endtask

  initial begin
    // Monitor + UART tick model, sampling on the falling edge.
    fork
      forever begin
        @(negedge clk);
        if (tx_start === 1'b1) begin
          check("tx_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            pos      = EXP_BYTES - sb.size();
            exp_byte = sb.pop_front();
            check("tx_byte", 32'(tx_data), 32'(exp_byte));
            if (pos == 0) begin
              first_tx_cyc = cyc;
              first_byte   = tx_data;
            end else begin
              exp_gap = ((mode == 0) ? 5 : 101) + ((pos % 4 == 0) ? 2 : 0);
              if (cyc - last_tx_cyc != exp_gap) gap_bad++;
            end
          end
          last_tx_cyc = cyc;
          tx_total++;
          since = 0;
        end else if (since < 1000) begin
          since++;
        end
        if (done === 1'b1) begin
          done_total++;
          done_cyc = cyc;
        end
        if (stab_en && tx_start !== 1'b1 && tx_data !== prev_tx_data) stab_bad++;
        prev_tx_data = tx_data;
        tx_done_tick = (mode == 0) ? (since == 4) : (since < 20 || since >= 100);
      end
    join_none

    // Reset values, then 10 idle cycles.
    repeat (3) @(negedge clk);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_reg_addr", 32'(reg_addr), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("idle_tx_count", 32'(tx_total), 32'd0);
    check("idle_done_count", 32'(done_total), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_tx_data", 32'(tx_data), 32'd0);

    // A: short tick, start pulsed in WAIT and in DONE, pc/cycles snapshot.
    mode      = 0;
    pc_in     = 32'h0000_0010;
    cycles_in = 32'h0000_002A;
    push_dump(pc_in, cycles_in);
    base_tx   = tx_total;
    base_done = done_total;
    pulse_start();
    pc_in     = 32'hFFFF_FFFF;
    cycles_in = 32'hFFFF_FFFF;
    wait_tx(base_tx + 1, 20);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("a_done_start_ignored", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    #1;
    check("a_byte_count", 32'(tx_total - base_tx), 32'(EXP_BYTES));
    check("a_done_count", 32'(done_total - base_done), 32'd1);
    check("a_busy_low", 32'(busy_low), 32'd0);
    check("a_first_latency", 32'(first_tx_cyc - start_cyc), 32'd3);
    check("a_done_latency", 32'(done_cyc - last_tx_cyc), 32'd5);
    check("a_gap_errors", 32'(gap_bad), 32'd0);
    check("a_sb_empty", 32'(sb.size()), 32'd0);
    check("a_idle_reg_addr", 32'(reg_addr), 32'd0);

    // B: tick already high on WAIT entry, drops, rises 100 cycles after tx_start.
    mode = 1;
    repeat (120) @(negedge clk);
    pc_in     = 32'hDEAD_BEEF;
    cycles_in = 32'h1234_5678;
    push_dump(pc_in, cycles_in);
    base_tx   = tx_total;
    base_done = done_total;
    stab_en   = 1'b1;
    pulse_start();
    pc_in = 32'h0;
    wait_done(40000);
    repeat (5) @(negedge clk);
    #1;
    stab_en = 1'b0;
    check("b_byte_count", 32'(tx_total - base_tx), 32'(EXP_BYTES));
    check("b_done_count", 32'(done_total - base_done), 32'd1);
    check("b_busy_low", 32'(busy_low), 32'd0);
    check("b_tx_data_stable", 32'(stab_bad), 32'd0);
    check("b_gap_errors", 32'(gap_bad), 32'd0);
    check("b_sb_empty", 32'(sb.size()), 32'd0);

    // C: reset after byte 7, then a fresh dump restarts at the PC byte.
    mode = 0;
    repeat (10) @(negedge clk);
    pc_in     = 32'h0000_0010;
    cycles_in = 32'h0000_002A;
    push_dump(pc_in, cycles_in);
    base_tx   = tx_total;
    base_done = done_total;
    pulse_start();
    wait_tx(base_tx + 7, 200);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("c_rst_busy", 32'(busy), 32'd0);
    check("c_rst_tx_start", 32'(tx_start), 32'd0);
    check("c_rst_done", 32'(done), 32'd0);
    check("c_rst_tx_data", 32'(tx_data), 32'd0);
    reset = 1'b0;
    sb.delete();
    repeat (20) @(negedge clk);
    #1;
    check("c_bytes_before_reset", 32'(tx_total - base_tx), 32'd7);
    check("c_no_done", 32'(done_total - base_done), 32'd0);
    push_dump(pc_in, cycles_in);
    base_tx   = tx_total;
    base_done = done_total;
    pulse_start();
    wait_done(3000);
    repeat (5) @(negedge clk);
    #1;
    check("c_restart_first_byte", 32'(first_byte), 32'h10);
    check("c_byte_count", 32'(tx_total - base_tx), 32'(EXP_BYTES));
    check("c_done_count", 32'(done_total - base_done), 32'd1);
    check("c_gap_errors", 32'(gap_bad), 32'd0);
    check("c_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
